// File: rtl/decode_out_queue.sv
// rtl/decode_out_queue.sv - FIFO of decoded instruction bundles between decode and execute
module decode_out_queue #(
  parameter int DEPTH = 2,
  parameter int IR_W  = 16,
  parameter int PC_W  = 16,
  parameter int E_W   = 6,
  parameter int W_W   = 2,
  parameter int SC_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IR_W-1:0]          in_ir,
  input  logic [PC_W-1:0]          in_npc,
  input  logic [E_W-1:0]           in_e_control,
  input  logic [W_W-1:0]           in_w_control,
  input  logic                     in_m_control,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IR_W-1:0]          ir,
  output logic [PC_W-1:0]          npc_out,
  output logic [E_W-1:0]           e_control,
  output logic [W_W-1:0]           w_control,
  output logic                     m_control,
  output logic [$clog2(DEPTH):0]   count,
  output logic [SC_W-1:0]          stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = IR_W + PC_W + E_W + W_W + 1;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [BW-1:0] head;

  // Ready depends on registered occupancy only, so a full queue never accepts even while popping.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[wr_ptr] <= {in_ir, in_npc, in_e_control, in_w_control, in_m_control};
    end
  end

  // Flush does not clear the back-pressure statistic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign head = out_valid ? mem[rd_ptr] : '0;
  assign {ir, npc_out, e_control, w_control, m_control} = head;

endmodule

// File: doc/decode_out_queue.md
DECODE_OUT_QUEUE -- requirements
Module: decode_out_queue

Interface
REQ-001 Parameter DEPTH, default 2: number of buffered decode bundles; power of two, >= 2.
REQ-002 Parameter IR_W, default 16: instruction register width.
REQ-003 Parameter PC_W, default 16: next-PC width.
REQ-004 Parameter E_W, default 6: execute control width.
REQ-005 Parameter W_W, default 2: writeback control width.
REQ-006 Parameter SC_W, default 8: stall counter width.
REQ-007 clock  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 flush  input  1  synchronous discard of all buffered bundles (branch redirect).
REQ-010 in_valid  input  1  decode stage presents a bundle.
REQ-011 in_ready  output  1  queue accepts a bundle this cycle.
REQ-012 in_ir  input  IR_W  decoded instruction.
REQ-013 in_npc  input  PC_W  next PC of that instruction.
REQ-014 in_e_control  input  E_W  execute controls.
REQ-015 in_w_control  input  W_W  writeback controls.
REQ-016 in_m_control  input  1  memory control.
REQ-017 out_valid  output  1  head bundle valid toward execute.
REQ-018 out_ready  input  1  execute consumes the head bundle.
REQ-019 ir, npc_out, e_control, w_control, m_control  output  IR_W/PC_W/E_W/W_W/1  head bundle fields.
REQ-020 count  output  clog2(DEPTH)+1  current occupancy.
REQ-021 stall_cnt  output  SC_W  saturating count of back-pressure cycles.

Function
REQ-022 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-023 in_ready SHALL be (count < DEPTH), combinational from registered count only; no dependence on out_ready (no full-bypass).
REQ-024 out_valid SHALL be (count != 0).
REQ-025 Output fields SHALL show the head entry when out_valid=1, and all-zero (NOP bundle) when out_valid=0.
REQ-026 Latency: a bundle pushed into an empty queue appears at outputs with out_valid=1 in the next cycle.
REQ-027 Order SHALL be strict FIFO; fields of one bundle never mix with another.
REQ-028 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-029 Full (count=DEPTH): in_ready=0; in_valid is ignored; pop alone decrements count.
REQ-030 Empty: out_ready is ignored; count never underflows.
REQ-031 Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-032 flush=1: next cycle count=0, pointers=0, out_valid=0; any push or pop in the same cycle is discarded.
REQ-033 stall_cnt increments by 1 each cycle with out_valid=1 && out_ready=0, saturates at 2^SC_W-1, clears only on reset (not on flush).
REQ-034 Storage array contents need not be reset; outputs never expose storage while out_valid=0.

Reset
REQ-035 reset low SHALL immediately force count=0, pointers=0, stall_cnt=0, out_valid=0, in_ready=1, all output fields 0.
REQ-036 Reset asserted mid-transfer discards all buffered bundles; the first push after deassertion behaves as into an empty queue.
REQ-037 Reset deassertion is assumed synchronised to clock externally; the block takes no action on deassertion beyond resuming operation.

Verification
REQ-038 Empty, push ir=16'h1234 npc=16'h3001 e=6'h2A w=2'b10 m=1 -> next cycle out_valid=1, exact fields, count=1.
REQ-039 DEPTH=2, out_ready=0, push A,B,C -> in_ready=0 after B, C not accepted, count=2, stall_cnt increments each cycle.
REQ-040 Full, in_valid=1 and out_ready=1 same cycle -> A popped, C not taken that cycle, count=1; next cycle C accepted, order B then C.
REQ-041 count=2, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, fields 0; pushed bundle lost.
REQ-042 SC_W=8, hold back-pressure 300 cycles -> stall_cnt=255, then flush leaves 255; reset low -> stall_cnt=0 immediately, asynchronously.
REQ-043 Streaming in_valid=out_ready=1 for 3*DEPTH+1 bundles -> one bundle per cycle, pointer wrap correct, output sequence identical to input.
